// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcode encodings, immediate formats and the decoded entry layout.
package rv32i_types;

  localparam int unsigned Xlen = 32;

  typedef enum logic [6:0] {
    op_lui   = 7'h37,
    op_auipc = 7'h17,
    op_jal   = 7'h6f,
    op_jalr  = 7'h67,
    op_br    = 7'h63,
    op_load  = 7'h03,
    op_store = 7'h23,
    op_imm   = 7'h13,
    op_reg   = 7'h33,
    op_csr   = 7'h73
  } rv32i_opcode;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            illegal;
  } decoded_instr_t;

endpackage

// File: rtl/rv32i_field_decode.sv
// Combinational RV32I field decode: raw word + PC -> decoded_instr_t.
// Optional unknown-opcode flagging is built only when DQ_ILLEGAL_CHECK_EN is defined.
module rv32i_field_decode
  import rv32i_types::*;
(
  input  logic [31:0]     instr,
  input  logic [Xlen-1:0] pc,
  output decoded_instr_t  dec
);

  imm_fmt_t fmt;
  logic     keep_rd, keep_rs1, keep_rs2;

  // Classify opcode into immediate format and which register indices are meaningful.
  always_comb begin
    fmt      = FMT_NONE;
    keep_rd  = 1'b0;
    keep_rs1 = 1'b0;
    keep_rs2 = 1'b0;
    case (instr[6:0])
      op_lui, op_auipc: begin fmt = FMT_U; keep_rd = 1'b1; end
      op_jal:           begin fmt = FMT_J; keep_rd = 1'b1; end
      op_jalr, op_load, op_imm: begin
        fmt      = FMT_I;
        keep_rd  = 1'b1;
        keep_rs1 = 1'b1;
      end
      op_br:    begin fmt = FMT_B; keep_rs1 = 1'b1; keep_rs2 = 1'b1; end
      op_store: begin fmt = FMT_S; keep_rs1 = 1'b1; keep_rs2 = 1'b1; end
      op_reg:   begin keep_rd = 1'b1; keep_rs1 = 1'b1; keep_rs2 = 1'b1; end
      default:  ;
    endcase
  end

`ifdef DQ_ILLEGAL_CHECK_EN
  logic known;

  // Anything outside the nine base opcodes plus CSR is flagged.
  always_comb begin
    known = 1'b0;
    case (instr[6:0])
      op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg,
      op_csr:  known = 1'b1;
      default: known = 1'b0;
    endcase
  end
`endif

  // Assemble the decoded entry with zeroed unused indices and the format-selected immediate.
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.opcode  = instr[6:0];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.rd      = keep_rd  ? instr[11:7]  : 5'd0;
    dec.rs1     = keep_rs1 ? instr[19:15] : 5'd0;
    dec.rs2     = keep_rs2 ? instr[24:20] : 5'd0;
    case (fmt)
      FMT_I:   dec.imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   dec.imm = {instr[31:12], 12'd0};
      FMT_J:   dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: dec.imm = 32'd0;
    endcase
`ifdef DQ_ILLEGAL_CHECK_EN
    dec.illegal = ~known;
`else
    dec.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered decode stage: decodes RV32I words at enqueue and holds DEPTH entries in a FIFO.
// Optional feature macro: DQ_ILLEGAL_CHECK_EN (unknown-opcode flag on out_illegal).
module instr_decode_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  decoded_instr_t       mem [DEPTH];
  decoded_instr_t       enq_dec;
  decoded_instr_t       head;
  logic [PtrW-1:0]      wptr, rptr;
  logic                 full, empty, push, pop;

  rv32i_field_decode u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (enq_dec)
  );

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AddrW] != rptr[AddrW]) && (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
  assign in_ready = ~full;
  assign out_valid = ~empty;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign count    = wptr - rptr;

  // Pointer update; flush clears the queue and discards any concurrent push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage is left unreset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AddrW-1:0]] <= enq_dec;
  end

  // Head fields are forced to zero while the queue is empty.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rptr[AddrW-1:0]];
  end

  assign out_pc      = head.pc;
  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

endmodule
